// File: rtl/fp_pack.sv
// fp_pack: normalize, round and pack an unpacked operand to binary32 plus fflags; two-stage valid/ready pipe (in_*: operand side, out_*: result side, rm_i: RISC-V rounding mode)
module fp_pack #(
  parameter int FLen = 32,
  parameter int ExpLen = 8,
  parameter int SigLen = 23
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic              sign_i,
  input  logic [ExpLen+1:0] exp_i,
  input  logic [SigLen+3:0] sig_i,
  input  logic              sticky_i,
  input  logic              nan_i,
  input  logic              inv_i,
  input  logic              inf_i,
  input  logic [2:0]        rm_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [FLen-1:0]   result_o,
  output logic [4:0]        fflags_o
);
  logic s1_valid, s1_adv, s2_adv;
  logic [4:0] p, sh;
  logic signed [10:0] e, d;
  logic [26:0] norm;
  logic [25:0] den;
  logic stk, tiny;
  logic [10:0] bexp;
  logic s1_sign, s1_stk, s1_zero, s1_nan, s1_inv, s1_inf;
  logic [25:0] s1_sig;
  logic [10:0] s1_bexp;
  logic [2:0] s1_rm;
  logic g, nx, inc;
  logic [24:0] sum;
  logic [22:0] mant;
  logic [10:0] ex;
  logic [31:0] ovf_res, res;
  logic [4:0] flg;
  assign s2_adv = !out_valid_o | out_ready_i;
  assign s1_adv = !s1_valid | s2_adv;
  assign in_ready_o = s1_adv;
  always_comb begin
    p = '0;
    for (int i = 0; i < 27; i++) p = sig_i[i] ? i[4:0] : p;
    e = $signed({exp_i[9], exp_i}) + $signed({6'd0, p}) - 11'sd25;
    norm = p == 5'd26 ? sig_i >> 1 : sig_i << (5'd25 - p);
    tiny = e < -11'sd126;
    d = -11'sd126 - e;
    sh = !tiny ? 5'd0 : d > 11'sd27 ? 5'd27 : d[4:0];
    den = 26'(norm >> sh);
    stk = sticky_i | (p == 5'd26 & sig_i[0]) | (|(norm & ~(27'h7ffffff << sh)));
    bexp = tiny ? 11'd0 : e + 11'sd127;
  end
  always_comb begin
    g = s1_sig[1];
    nx = s1_sig[1] | s1_sig[0] | s1_stk;
    inc = s1_rm == 3'd0 ? g & (s1_sig[0] | s1_stk | s1_sig[2]) :
          s1_rm == 3'd2 ? s1_sign & nx :
          s1_rm == 3'd3 ? !s1_sign & nx :
          s1_rm == 3'd4 ? g : 1'b0;
    sum = {1'b0, s1_sig[25:2]} + 25'(inc);
    mant = sum[24] ? sum[23:1] : sum[22:0];
    // a subnormal rounding up into the hidden bit becomes the smallest normal
    ex = s1_bexp + 11'(sum[24]) + 11'(s1_bexp == 11'd0 & sum[23]);
    ovf_res = s1_rm == 3'd1 | (s1_rm == 3'd2 & !s1_sign) | (s1_rm == 3'd3 & s1_sign) ?
              {s1_sign, 31'h7f7fffff} : {s1_sign, 31'h7f800000};
    res = s1_rm > 3'd4 | s1_nan ? 32'h7fc00000 :
          s1_inf ? {s1_sign, 8'hff, 23'd0} :
          s1_zero ? {s1_sign, 31'd0} :
          ex >= 11'd255 ? ovf_res : {s1_sign, ex[7:0], mant};
    flg = s1_rm > 3'd4 ? 5'h10 :
          s1_nan ? {s1_inv, 4'd0} :
          s1_inf | s1_zero ? 5'd0 :
          ex >= 11'd255 ? 5'h05 : {3'd0, nx & ex == 11'd0, nx};
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      s1_valid <= 1'b0;
      out_valid_o <= 1'b0;
      result_o <= '0;
      fflags_o <= '0;
    end else begin
      if (s1_adv) s1_valid <= in_valid_i;
      if (s2_adv) out_valid_o <= s1_valid;
      if (s2_adv & s1_valid) begin
        result_o <= res;
        fflags_o <= flg;
      end
    end
  end
  always_ff @(posedge clk_i) begin
    if (s1_adv & in_valid_i) begin
      s1_sign <= sign_i;
      s1_sig <= den;
      s1_stk <= stk;
      s1_bexp <= bexp;
      s1_zero <= sig_i == '0;
      s1_nan <= nan_i;
      s1_inv <= inv_i;
      s1_inf <= inf_i;
      s1_rm <= rm_i;
    end
  end
endmodule
